// File: rtl/dbg_pkg.sv
// dbg_pkg: shared FSM encoding and data/tag field constants for the debug log arbiter.
package dbg_pkg;
    localparam int DATA_W = 64;
    localparam int TAG_HI = 63;
    localparam int TAG_LO = 60;
    localparam int ID_W   = TAG_HI - TAG_LO + 1;
    typedef enum logic {ARB = 1'b0, XFER = 1'b1} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin winner search starting just above the last granted index.
module rr_pick
    import dbg_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]    valid,
    input  logic [ID_W-1:0] last,
    output logic [ID_W-1:0] win,
    output logic            found
);
    localparam int IW = $clog2(N);
    logic [IW-1:0] cand;
    // Scan farthest to nearest so the nearest valid index after last overwrites earlier hits.
    always_comb begin
        win = '0;
        cand = '0;
        found = |valid;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % N);
            if (valid[cand]) win = ID_W'(cand);
        end
    end
endmodule

// File: rtl/dbg_log_arbiter.sv
// dbg_log_arbiter: round-robin merge of N_REQ debug log streams into the UART bridge FIFO,
// granting bursts of up to BURST words and optionally tagging each word with its source ID.
module dbg_log_arbiter
    import dbg_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int BURST  = 8,
    parameter int TAG_EN = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [DATA_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_we,
    output logic [DATA_W-1:0]       fifo_data,
    output logic [ID_W-1:0]         gnt_id,
    output logic                    busy
);
    localparam int IW = $clog2(N_REQ);

    state_t          state_q, state_d;
    logic [ID_W-1:0] gnt_q, gnt_d, last_q, last_d, win;
    logic [7:0]      cnt_q, cnt_d;
    logic            found, gnt_valid, hs;
    logic [IW-1:0]   gi;
    logic [DATA_W-1:0] words [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_word
        assign words[i] = req_data[DATA_W*i +: DATA_W];
    end

    rr_pick #(.N(N_REQ)) u_pick (
        .valid(req_valid),
        .last (last_q),
        .win  (win),
        .found(found)
    );

    always_comb begin
        gi = gnt_q[IW-1:0];
        gnt_valid = req_valid[gi];
        hs = state_q == XFER && gnt_valid && !fifo_full;
        fifo_we = hs;
        req_ready = hs ? N_REQ'(1) << gnt_q : '0;
        fifo_data = TAG_EN != 0 ? {gnt_q, words[gi][TAG_LO-1:0]} : words[gi];
        gnt_id = gnt_q;
        busy = state_q == XFER;
        state_d = state_q;
        gnt_d = gnt_q;
        last_d = last_q;
        cnt_d = hs ? cnt_q + 8'd1 : cnt_q;
        if (state_q == ARB) begin
            if (found) begin
                state_d = XFER;
                gnt_d = win;
                cnt_d = '0;
            end
        end else if (!gnt_valid || (hs && cnt_q + 8'd1 == 8'(BURST))) begin
            // A dropped valid wins over a simultaneous stall release: give the slot back.
            state_d = ARB;
            last_d = gnt_q;
            gnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB;
            gnt_q <= '0;
            last_q <= ID_W'(N_REQ - 1);
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            last_q <= last_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_dbg_log_arbiter.sv
// tb_dbg_log_arbiter: directed scoreboard bench for dbg_log_arbiter (N_REQ=4, BURST=8, TAG_EN=1).
module tb_dbg_log_arbiter;
    localparam int N = 4;

    logic clk = 1'b0, rst = 1'b0, fifo_full = 1'b0;
    logic [N-1:0] req_valid, req_ready, rdy_seen;
    logic [64*N-1:0] req_data;
    logic fifo_we, busy, busy_prev = 1'b0;
    logic [63:0] fifo_data;
    logic [3:0] gnt_id;
    logic [63:0] src [N][$];
    logic [63:0] exp_q [$];
    logic [3:0] glog [$];
    int wr_cyc [$];
    int cyc = 0, checks = 0, errors = 0;
    int c0, n0, g0;

    dbg_log_arbiter #(.N_REQ(N), .BURST(8), .TAG_EN(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .fifo_full(fifo_full),
        .fifo_we  (fifo_we),
        .fifo_data(fifo_data),
        .gnt_id   (gnt_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mkw(input int i, input int k);
        return {4'hF, 4'(i), 48'd0, 8'(k)};
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = src[i].size() != 0;
            req_data[64*i +: 64] = src[i].size() != 0 ? src[i][0] : 64'd0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (rdy_seen[i] && src[i].size() != 0) void'(src[i].pop_front());
        drive();
    endtask

    task automatic load(input int i, input int k0, input int n);
        for (int k = 0; k < n; k++) src[i].push_back(mkw(i, k0 + k));
    endtask

    task automatic expect_src(input int i, input int from, input int n);
        logic [63:0] w;
        for (int k = 0; k < n; k++) begin
            w = src[i][from + k];
            exp_q.push_back({4'(i), w[59:0]});
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic drain(input string tag);
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) tick();
        chk(tag, 64'(exp_q.size()), 64'd0);
        repeat (3) tick();
    endtask

    // Monitor: scoreboard pop on every FIFO write, plus stall and grant logging.
    always @(negedge clk) begin
        rdy_seen = req_ready;
        if (fifo_full) chk("stall_quiet", {59'd0, fifo_we, req_ready}, 64'd0);
        if (fifo_we) begin
            wr_cyc.push_back(cyc);
            chk("ready_matches_grant", 64'(req_ready), 64'(4'b1 << gnt_id));
            if (exp_q.size() != 0) chk("fifo_data", fifo_data, exp_q.pop_front());
            else begin
                checks++;
                errors++;
                $error("FAIL unexpected_write: observed data 0x%0h, required no write", fifo_data);
            end
        end
        if (busy && !busy_prev) glog.push_back(gnt_id);
        busy_prev = busy;
    end

    initial begin
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_gnt", gnt_id, 4'd0);
        chk("rst_we", fifo_we, 1'b0);
        chk("rst_ready", req_ready, 4'd0);
        rst = 1'b1;
        tick();

        // Single requester 2, three words, tag replaces top nibble.
        src[2].push_back(64'h1111_1111_1111_1111);
        src[2].push_back(64'h2222_2222_2222_2222);
        src[2].push_back(64'h3333_3333_3333_3333);
        expect_src(2, 0, 3);
        drive();
        glog.delete();
        c0 = cyc;
        n0 = wr_cyc.size();
        repeat (4) tick();
        chk("a_busy_hold", busy, 1'b1);
        tick();
        chk("a_busy_fall", busy, 1'b0);
        chk("a_writes", 64'(wr_cyc.size() - n0), 64'd3);
        for (int k = 0; k < 3; k++)
            if (wr_cyc.size() > n0 + k) chk("a_write_cycle", 64'(wr_cyc[n0 + k] - c0), 64'(k + 1));
        chk("a_exp_empty", 64'(exp_q.size()), 64'd0);
        chk("a_grant_count", 64'(glog.size()), 64'd1);
        if (glog.size() > 0) chk("a_grant", glog[0], 4'd2);

        // All four requesters valid: 0,1,2,3,0 with 8 words each and one ARB cycle between.
        do_reset();
        glog.delete();
        n0 = wr_cyc.size();
        load(0, 0, 16);
        load(1, 0, 8);
        load(2, 0, 8);
        load(3, 0, 8);
        expect_src(0, 0, 8);
        expect_src(1, 0, 8);
        expect_src(2, 0, 8);
        expect_src(3, 0, 8);
        expect_src(0, 8, 8);
        drive();
        drain("b_drain");
        chk("b_writes", 64'(wr_cyc.size() - n0), 64'd40);
        chk("b_grants", 64'(glog.size()), 64'd5);
        for (int k = 0; k < 5; k++)
            if (k < glog.size()) chk("b_grant_order", glog[k], 4'(k % 4));
        if (wr_cyc.size() >= n0 + 40) begin
            chk("b_burst_back2back", 64'(wr_cyc[n0 + 7] - wr_cyc[n0]), 64'd7);
            chk("b_idle_gap", 64'(wr_cyc[n0 + 8] - wr_cyc[n0 + 7]), 64'd2);
            chk("b_span", 64'(wr_cyc[n0 + 39] - wr_cyc[n0]), 64'd43);
        end

        // FIFO full for 5 cycles after 3 words of an 8-word burst.
        do_reset();
        glog.delete();
        n0 = wr_cyc.size();
        load(0, 0, 8);
        expect_src(0, 0, 8);
        drive();
        for (int t = 0; t < 20 && wr_cyc.size() - n0 < 3; t++) tick();
        fifo_full = 1'b1;
        repeat (5) tick();
        chk("c_stall_count", 64'(wr_cyc.size() - n0), 64'd3);
        chk("c_stall_busy", busy, 1'b1);
        chk("c_stall_gnt", gnt_id, 4'd0);
        fifo_full = 1'b0;
        drain("c_drain");
        chk("c_total", 64'(wr_cyc.size() - n0), 64'd8);
        chk("c_single_grant", 64'(glog.size()), 64'd1);

        // Requester 1 drops valid after 2 words; 3 is next, then 0 proves last_gnt moved to 3 via 1.
        do_reset();
        glog.delete();
        load(1, 0, 2);
        load(3, 0, 2);
        expect_src(1, 0, 2);
        expect_src(3, 0, 2);
        drive();
        tick();
        tick();
        load(0, 0, 2);
        expect_src(0, 0, 2);
        drive();
        drain("d_drain");
        chk("d_grants", 64'(glog.size()), 64'd3);
        if (glog.size() >= 3) begin
            chk("d_grant0", glog[0], 4'd1);
            chk("d_grant1", glog[1], 4'd3);
            chk("d_grant2", glog[2], 4'd0);
        end

        // Asynchronous reset mid-burst of requester 0.
        do_reset();
        n0 = wr_cyc.size();
        load(0, 0, 8);
        expect_src(0, 0, 8);
        drive();
        for (int t = 0; t < 20 && wr_cyc.size() - n0 < 2; t++) tick();
        #1 rst = 1'b0;
        #1;
        chk("e_async_busy", busy, 1'b0);
        chk("e_async_we", fifo_we, 1'b0);
        chk("e_async_ready", req_ready, 4'd0);
        chk("e_async_gnt", gnt_id, 4'd0);
        chk("e_words_left", 64'(src[0].size()), 64'd6);
        exp_q.delete();
        expect_src(0, 0, src[0].size());
        g0 = glog.size();
        tick();
        tick();
        rst = 1'b1;
        drain("e_drain");
        chk("e_total", 64'(wr_cyc.size() - n0), 64'd8);
        if (glog.size() > g0) chk("e_first_grant", glog[g0], 4'd0);
        else chk("e_regrant_seen", 64'(glog.size() - g0), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dbg_log_arbiter.md
DBG_LOG_ARBITER -- requirements
Module: dbg_log_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters (legal range 2..16).
REQ-002 Parameter BURST, default 8, SHALL set the maximum words accepted per grant (legal range 1..255).
REQ-003 Parameter TAG_EN, default 1, SHALL enable replacing data bits [63:60] with the requester ID.
REQ-004 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 req_valid  input  N_REQ  SHALL carry one per-requester "word available" flag.
REQ-007 req_data  input  64*N_REQ  SHALL carry the packed words; requester i occupies bits [64*i+63:64*i].
REQ-008 req_ready  output  N_REQ  SHALL carry one per-requester word-accepted strobe.
REQ-009 fifo_full  input  1  SHALL be the full flag of the downstream UART debug bridge FIFO.
REQ-010 fifo_we  output  1  SHALL be the write enable to the bridge FIFO.
REQ-011 fifo_data  output  64  SHALL carry the word written to the bridge FIFO.
REQ-012 gnt_id  output  4  SHALL carry the currently granted requester index (0 when idle).
REQ-013 busy  output  1  SHALL be high while a grant is held.

Function
REQ-014 The FSM SHALL have exactly two states, ARB and XFER; the reset state is ARB.
REQ-015 In ARB with any req_valid high, the block SHALL register the first valid requester searching upward from (last_gnt+1) mod N_REQ, wrapping, and SHALL enter XFER next cycle.
REQ-016 In ARB with no req_valid, the block SHALL stay in ARB and SHALL assert no req_ready and no fifo_we.
REQ-017 In XFER, a handshake SHALL occur on any cycle where req_valid[gnt] = 1 and fifo_full = 0.
REQ-018 On a handshake, req_ready[gnt] and fifo_we SHALL be high combinationally in the same cycle, with zero latency.
REQ-019 fifo_data SHALL equal req_data[gnt]; when TAG_EN = 1, bits [63:60] SHALL be replaced by gnt_id.
REQ-020 req_ready for non-granted requesters SHALL be 0 at all times.
REQ-021 Each handshake SHALL increment the 8-bit burst counter; the handshake that makes the count equal BURST SHALL return the FSM to ARB.
REQ-022 When req_valid[gnt] = 0 in XFER, the block SHALL return to ARB next cycle with no write.
REQ-023 When fifo_full = 1 in XFER, the block SHALL stall: no write, no ready, counter held, grant held, no timeout.
REQ-024 When fifo_full and req_valid[gnt] both fall in the same cycle, the no-valid rule (REQ-022) SHALL take priority.
REQ-025 last_gnt SHALL update to gnt on leaving XFER; the burst counter SHALL clear on entering XFER.
REQ-026 Minimum arbitration overhead SHALL be one ARB cycle per grant, giving a sustained throughput of BURST/(BURST+1) words per cycle.
REQ-027 The block SHALL never write when fifo_full = 1, and SHALL never drop or duplicate a word.

Reset
REQ-028 Reset SHALL force state = ARB, last_gnt = N_REQ-1 (so requester 0 wins first), burst counter = 0, gnt_id = 0 and busy = 0.
REQ-029 Reset SHALL force fifo_we = 0 and req_ready = 0, since both derive from state.
REQ-030 Reset asserted mid-burst SHALL abort the burst immediately; a word not yet handshaken is not written.

Structure
REQ-031 Shared package dbg_pkg SHALL hold the FSM state encoding (ARB = 1'b0, XFER = 1'b1), the TAG field position constants (63, 60) and the data width constant 64.
REQ-032 The round-robin next-index search SHALL be a sub-module rr_pick (N_REQ inputs, last index in, winner index and found flag out); all other logic SHALL remain flat.

Verification
REQ-033 Requester 2 only, 3 words 0x11..11, 0x22..22, 0x33..33, TAG_EN = 1 -> fifo_data 0x21..11, 0x22..22, 0x23..33 on consecutive cycles after 1 ARB cycle; busy falls 1 cycle later.
REQ-034 All 4 requesters continuously valid, BURST = 8 -> grant order 0, 1, 2, 3, 0; exactly 8 writes per grant; 1 idle cycle between grants.
REQ-035 fifo_full held high for 5 cycles mid-burst after 3 words -> no fifo_we or req_ready during the stall; 5 remaining words follow; total 8 with none lost.
REQ-036 Requester 1 drops valid after 2 words while requester 3 is valid -> return to ARB; requester 3 granted; last_gnt = 1.
REQ-037 rst pulsed low during XFER of requester 0 -> outputs 0 asynchronously; after release, requester 0 wins first arbitration again.
